// File: rtl/manual_step_ctrl_pkg.sv
// Shared types and constants for the manual parameter steppers (amplitude, frequency, phase).
package manual_step_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      HOLD = 2'd2
   } stateT;

   // Menu selection codes driven by the button/menu logic
   localparam logic [3:0] ACTIVE_NONE  = 4'h0;
   localparam logic [3:0] ACTIVE_FREQ  = 4'h1;
   localparam logic [3:0] ACTIVE_AMP   = 4'h2;
   localparam logic [3:0] ACTIVE_PHASE = 4'h3;

   // Number of decimal digits needed to show n (n < 10**10)
   function automatic int unsigned bcd_digits(input int unsigned n);
      int unsigned d;
      int unsigned v;
      d = 1;
      v = n;
      for (int i = 0; i < 10; i++) begin
         if (v >= 10) begin
            v = v / 10;
            d = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/manual_step_ctrl_if.sv
// Button/menu side controls and DDS/LCD side results of one manual stepper instance.
interface manual_step_ctrl_if #(
   parameter int unsigned PCT_W      = 7,
   parameter int unsigned WORD_W     = 14,
   parameter int unsigned BCD_DIGITS = 3
);
   logic                    trigup;
   logic                    trigdown;
   logic                    coarse;
   logic [3:0]              active;
   logic                    load_en;
   logic [PCT_W-1:0]        load_pct;
   logic [WORD_W-1:0]       word_out;
   logic [4*BCD_DIGITS-1:0] pct_bcd;
   logic                    busy;
   logic                    done;

   modport master (
      output trigup, trigdown, coarse, active, load_en, load_pct,
      input  word_out, pct_bcd, busy, done
   );

   modport slave (
      input  trigup, trigdown, coarse, active, load_en, load_pct,
      output word_out, pct_bcd, busy, done
   );
endinterface

// File: rtl/manual_step_ctrl_bin2bcd_seq.sv
// Sequential double-dabble: one add-3 cycle and one shift cycle per input bit.
module bin2bcd_seq #(
   parameter int unsigned BIN_W  = 7,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  done
);
   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned SH_W  = BCD_W + BIN_W;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   logic [SH_W-1:0]  shiftReg;
   logic [SH_W-1:0]  adjusted;
   logic [CNT_W-1:0] bitCnt;
   logic             addPhase;
   logic             running;

   // Digits of 5 or more get +3 so the following shift carries correctly
   always_comb begin : addThree
      adjusted = shiftReg;
      for (int d = 0; d < int'(DIGITS); d++) begin
         if (shiftReg[BIN_W + 4*d +: 4] >= 4'd5) begin
            adjusted[BIN_W + 4*d +: 4] = shiftReg[BIN_W + 4*d +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : convReg
      if (!rst_n) begin
         shiftReg <= '0;
         bitCnt   <= '0;
         addPhase <= 1'b0;
         running  <= 1'b0;
         bcd      <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            shiftReg <= {BCD_W'(0), bin};
            bitCnt   <= '0;
            addPhase <= 1'b1;
            running  <= 1'b1;
         end else if (running) begin
            if (bitCnt == CNT_W'(BIN_W)) begin
               bcd     <= shiftReg[BIN_W +: BCD_W];
               done    <= 1'b1;
               running <= 1'b0;
            end else if (addPhase) begin
               shiftReg <= adjusted;
               addPhase <= 1'b0;
            end else begin
               shiftReg <= shiftReg << 1;
               bitCnt   <= bitCnt + CNT_W'(1);
               addPhase <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/manual_step_ctrl.sv
// Manual stepper: turns up/down/load requests into a saturated percentage,
// a DDS control word (pct*STEP) and a BCD readout, with a post-update holdoff.
module manual_step_ctrl
   import manual_step_ctrl_pkg::*;
#(
   parameter int unsigned WORD_W      = 14,
   parameter int unsigned STEP        = 163,
   parameter int unsigned PCT_W       = 7,
   parameter int unsigned MAX_PCT     = 100,
   parameter int unsigned COARSE_MULT = 10,
   parameter int unsigned BCD_DIGITS  = bcd_digits(MAX_PCT),
   parameter logic [3:0]  ACTIVE_CODE = ACTIVE_AMP,
   parameter int unsigned HOLDOFF_W   = 24
) (
   input logic               clk,
   input logic               rst_n,
   manual_step_ctrl_if.slave bus
);
   localparam int unsigned PCT_IW = PCT_W + 1;
   localparam int unsigned BCD_W  = 4 * BCD_DIGITS;

   stateT                 state;
   stateT                 stateNext;
   logic                  actMatchQ;
   logic                  upQ;
   logic                  downQ;
   logic                  coarseQ;
   logic                  loadEnQ;
   logic [PCT_W-1:0]      loadPctQ;
   logic [PCT_W-1:0]      pct;
   logic [PCT_W-1:0]      pctNext;
   logic [HOLDOFF_W-1:0]  holdCnt;
   logic [HOLDOFF_W-1:0]  holdNext;
   logic [WORD_W-1:0]     wordOut;
   logic                  busyQ;
   logic                  convStart;
   logic                  convDone;
   logic [BCD_W-1:0]      convBcd;
   logic [PCT_IW-1:0]     incW;
   logic [PCT_IW-1:0]     pctW;
   logic [PCT_IW-1:0]     sumW;
   logic [PCT_W-1:0]      upPct;
   logic [PCT_W-1:0]      downPct;
   logic [PCT_W-1:0]      loadPct;

   // Single input register stage; every decision below uses these copies
   always_ff @(posedge clk or negedge rst_n) begin : inputReg
      if (!rst_n) begin
         actMatchQ <= 1'b0;
         upQ       <= 1'b0;
         downQ     <= 1'b0;
         coarseQ   <= 1'b0;
         loadEnQ   <= 1'b0;
         loadPctQ  <= '0;
      end else begin
         actMatchQ <= (bus.active == ACTIVE_CODE);
         upQ       <= bus.trigup;
         downQ     <= bus.trigdown;
         coarseQ   <= bus.coarse;
         loadEnQ   <= bus.load_en;
         loadPctQ  <= bus.load_pct;
      end
   end

   // Saturating step arithmetic, one bit wider than pct so nothing wraps
   always_comb begin : stepArith
      incW    = coarseQ ? PCT_IW'(COARSE_MULT) : PCT_IW'(1);
      pctW    = {1'b0, pct};
      sumW    = pctW + incW;
      upPct   = (sumW > PCT_IW'(MAX_PCT)) ? PCT_W'(MAX_PCT) : sumW[PCT_W-1:0];
      downPct = (pctW >= incW) ? PCT_W'(pctW - incW) : '0;
      loadPct = ({1'b0, loadPctQ} > PCT_IW'(MAX_PCT)) ? PCT_W'(MAX_PCT) : loadPctQ;
   end

   always_comb begin : fsmNext
      stateNext = state;
      pctNext   = pct;
      holdNext  = holdCnt;
      convStart = 1'b0;
      case (state)
         IDLE: begin
            if (loadEnQ) begin
               pctNext   = loadPct;
               convStart = 1'b1;
               stateNext = CONV;
            end else if (actMatchQ && upQ && !downQ) begin
               pctNext   = upPct;
               convStart = 1'b1;
               stateNext = CONV;
            end else if (actMatchQ && downQ && !upQ) begin
               pctNext   = downPct;
               convStart = 1'b1;
               stateNext = CONV;
            end
         end
         CONV: begin
            if (convDone) begin
               stateNext = HOLD;
            end
         end
         HOLD: begin
            if (holdCnt[HOLDOFF_W-1]) begin
               holdNext  = '0;
               stateNext = IDLE;
            end else begin
               holdNext = holdCnt + HOLDOFF_W'(1);
            end
         end
         default: begin
            holdNext  = '0;
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin : fsmReg
      if (!rst_n) begin
         state   <= IDLE;
         pct     <= '0;
         holdCnt <= '0;
         busyQ   <= 1'b0;
         wordOut <= '0;
      end else begin
         state   <= stateNext;
         pct     <= pctNext;
         holdCnt <= holdNext;
         busyQ   <= (stateNext != IDLE);
         wordOut <= WORD_W'(pct * STEP);
      end
   end

   // Converter samples pctNext on the same edge pct takes it
   bin2bcd_seq #(
      .BIN_W  (PCT_W),
      .DIGITS (BCD_DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (convStart),
      .bin   (pctNext),
      .bcd   (convBcd),
      .done  (convDone)
   );

   assign bus.word_out = wordOut;
   assign bus.pct_bcd  = convBcd;
   assign bus.busy     = busyQ;
   assign bus.done     = convDone;

endmodule

// File: tb/tb_manual_step_ctrl.sv
// Directed bench for manual_step_ctrl with a cycle-level reference model and literal spot checks.
module tb_manual_step_ctrl;

   localparam int PCT_W       = 7;
   localparam int WORD_W      = 14;
   localparam int STEP        = 163;
   localparam int MAX_PCT     = 100;
   localparam int COARSE_MULT = 10;
   localparam int BCD_DIGITS  = 3;
   localparam int HOLDOFF_W   = 4;
   localparam int CONV_LAT    = 2*PCT_W + 1;
   localparam int HOLD_LEN    = (1 << (HOLDOFF_W-1)) + 1;
   localparam int BUSY_LEN    = CONV_LAT + 1 + HOLD_LEN;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   manual_step_ctrl_if #(.PCT_W(PCT_W), .WORD_W(WORD_W), .BCD_DIGITS(BCD_DIGITS)) bus ();

   manual_step_ctrl #(
      .WORD_W(WORD_W), .STEP(STEP), .PCT_W(PCT_W), .MAX_PCT(MAX_PCT),
      .COARSE_MULT(COARSE_MULT), .BCD_DIGITS(BCD_DIGITS), .ACTIVE_CODE(4'h2),
      .HOLDOFF_W(HOLDOFF_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] toBcd(input int p);
      return 12'((p / 100) * 256 + ((p / 10) % 10) * 16 + (p % 10));
   endfunction

   // Reference model: requests seen one edge late, outputs follow the timing contract
   int          mPct  = 0;
   int          mAge  = -1;
   logic [13:0] mWord = '0;
   logic [11:0] mBcd  = '0;
   logic        mDone = 1'b0;
   logic        mBusy = 1'b0;
   logic        qAct = 0, qUp = 0, qDn = 0, qCoarse = 0, qLd = 0;
   int          qLdPct = 0;

   initial begin : model
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mPct = 0; mAge = -1; mWord = '0; mBcd = '0; mDone = 0; mBusy = 0;
            qAct = 0; qUp = 0; qDn = 0; qCoarse = 0; qLd = 0; qLdPct = 0;
         end else begin
            mDone = 1'b0;
            if (mAge >= 0) begin
               mAge++;
               if (mAge == 1) mWord = 14'(mPct * STEP);
               if (mAge == CONV_LAT) begin
                  mBcd  = toBcd(mPct);
                  mDone = 1'b1;
               end
               if (mAge == BUSY_LEN) begin
                  mBusy = 1'b0;
                  mAge  = -1;
               end
            end else begin
               int  inc;
               bit  go;
               inc = qCoarse ? COARSE_MULT : 1;
               go  = 1'b1;
               if (qLd)                     mPct = (qLdPct > MAX_PCT) ? MAX_PCT : qLdPct;
               else if (qAct && qUp && !qDn) mPct = (mPct + inc > MAX_PCT) ? MAX_PCT : mPct + inc;
               else if (qAct && qDn && !qUp) mPct = (mPct >= inc) ? mPct - inc : 0;
               else                          go = 1'b0;
               if (go) begin
                  mAge  = 0;
                  mBusy = 1'b1;
               end
            end
            qAct    = (bus.active == 4'h2);
            qUp     = bus.trigup;
            qDn     = bus.trigdown;
            qCoarse = bus.coarse;
            qLd     = bus.load_en;
            qLdPct  = int'(bus.load_pct);
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         check("word_out", 32'(bus.word_out), 32'(mWord));
         check("pct_bcd",  32'(bus.pct_bcd),  32'(mBcd));
         check("busy",     32'(bus.busy),     32'(mBusy));
         check("done",     32'(bus.done),     32'(mDone));
      end
   end

   task automatic pulse(input bit up, input bit dn, input bit ld, input int lp);
      bus.trigup   = up;
      bus.trigdown = dn;
      bus.load_en  = ld;
      bus.load_pct = 7'(lp);
      @(negedge clk);
      bus.trigup   = 1'b0;
      bus.trigdown = 1'b0;
      bus.load_en  = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 60);
      check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
   endtask

   task automatic waitIdle(input string tag, output int n);
      n = 0;
      while (bus.busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle_seen"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin : stim
      int n;
      bus.trigup = 0; bus.trigdown = 0; bus.coarse = 0; bus.active = 4'h0;
      bus.load_en = 0; bus.load_pct = '0;
      repeat (3) @(negedge clk);
      check("rst_word", 32'(bus.word_out), 32'd0);
      check("rst_bcd",  32'(bus.pct_bcd),  32'h000);
      check("rst_busy", 32'(bus.busy),     32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single fine step up from 0
      bus.active = 4'h2;
      pulse(1, 0, 0, 0);
      waitDone("up1");
      check("up1_bcd",  32'(bus.pct_bcd),  32'h001);
      check("up1_word", 32'(bus.word_out), 32'd163);
      check("up1_busy", 32'(bus.busy),     32'd1);
      waitIdle("up1", n);
      check("holdoff_len", 32'(n), 32'd10);

      // coarse step saturating at 100, then a saturated repeat
      pulse(0, 0, 1, 95);
      waitDone("ld95");
      check("ld95_bcd",  32'(bus.pct_bcd),  32'h095);
      check("ld95_word", 32'(bus.word_out), 32'd15485);
      waitIdle("ld95", n);
      bus.coarse = 1'b1;
      pulse(1, 0, 0, 0);
      waitDone("sat1");
      check("sat1_bcd",  32'(bus.pct_bcd),  32'h100);
      check("sat1_word", 32'(bus.word_out), 32'd16300);
      waitIdle("sat1", n);
      pulse(1, 0, 0, 0);
      waitDone("sat2");
      check("sat2_bcd",  32'(bus.pct_bcd),  32'h100);
      check("sat2_word", 32'(bus.word_out), 32'd16300);
      waitIdle("sat2", n);

      // coarse step down floors at 0, then up+down together does nothing
      pulse(0, 0, 1, 3);
      waitDone("ld3");
      check("ld3_bcd", 32'(bus.pct_bcd), 32'h003);
      waitIdle("ld3", n);
      pulse(0, 1, 0, 0);
      waitDone("floor");
      check("floor_bcd",  32'(bus.pct_bcd),  32'h000);
      check("floor_word", 32'(bus.word_out), 32'd0);
      waitIdle("floor", n);
      bus.coarse   = 1'b0;
      bus.trigup   = 1'b1;
      bus.trigdown = 1'b1;
      repeat (6) @(negedge clk);
      bus.trigup   = 1'b0;
      bus.trigdown = 1'b0;
      repeat (3) @(negedge clk);
      check("both_busy", 32'(bus.busy), 32'd0);

      // load without active match clamps; a trigger during busy is dropped
      bus.active = 4'h0;
      pulse(0, 0, 1, 127);
      repeat (3) @(negedge clk);
      bus.active = 4'h2;
      pulse(1, 0, 0, 0);
      waitDone("ld127");
      check("ld127_bcd",  32'(bus.pct_bcd),  32'h100);
      check("ld127_word", 32'(bus.word_out), 32'd16300);
      waitIdle("ld127", n);
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done) n++;
      end
      check("no_queued_done", 32'(n), 32'd0);

      // held trigger: ignored for another menu code, then one step per holdoff
      pulse(0, 0, 1, 0);
      waitDone("ld0");
      waitIdle("ld0", n);
      bus.active = 4'h3;
      bus.trigup = 1'b1;
      repeat (40) @(negedge clk);
      check("other_busy", 32'(bus.busy),    32'd0);
      check("other_bcd",  32'(bus.pct_bcd), 32'h000);
      bus.active = 4'h2;
      for (int i = 1; i <= 3; i++) begin
         waitDone("held");
         check("held_bcd",  32'(bus.pct_bcd),  32'(toBcd(i)));
         check("held_word", 32'(bus.word_out), 32'(i * STEP));
      end
      check("held_bcd3_lit", 32'(bus.pct_bcd), 32'h003);
      bus.trigup = 1'b0;
      waitIdle("held", n);

      // asynchronous reset in the middle of a conversion
      pulse(1, 0, 0, 0);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_word", 32'(bus.word_out), 32'd0);
      check("arst_bcd",  32'(bus.pct_bcd),  32'h000);
      check("arst_busy", 32'(bus.busy),     32'd0);
      check("arst_done", 32'(bus.done),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/manual_step_ctrl.md
Name: manual_step_ctrl

Overview:
- Parametrised manual control-word stepper: converts debounced up/down button triggers into a DDS control word plus a BCD percentage for the LCD.
- Successor to the fixed 14-bit/1% amplitude stepper. Adds generic width, step size and digit count; coarse (×10) steps; preset load; saturation; and busy/done status.
- Sits between the button/menu logic and the DDS serial writer and LCD driver. One instance per controlled parameter, selected by `active` code.

Parameters:
- WORD_W, 14, width of the DDS control word
- STEP, 163, control-word LSBs per one percent
- PCT_W, 7, width of the binary percentage
- MAX_PCT, 100, upper clamp of the percentage; MAX_PCT*STEP must fit in WORD_W
- COARSE_MULT, 10, percent per coarse step
- BCD_DIGITS, 3, BCD digits on pct_bcd
- ACTIVE_CODE, 4'h2, `active` value that enables this instance
- HOLDOFF_W, 24, holdoff counter width; holdoff ends when bit HOLDOFF_W-1 sets

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trigup  in  1  increment request (level, already debounced)
- trigdown  in  1  decrement request
- coarse  in  1  1: step by COARSE_MULT percent, 0: step by 1
- active  in  4  menu selection code
- load_en  in  1  preset load strobe
- load_pct  in  PCT_W  preset percentage
- word_out  out  WORD_W  control word to DDS (= pct*STEP)
- pct_bcd  out  4*BCD_DIGITS  percentage in BCD
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when a new pct_bcd is latched

Behaviour:
- Reset (async, rst_n=0): all outputs 0, pct=0, state IDLE, counters 0. Reset mid-conversion or mid-holdoff aborts immediately.
- Input stage: {active==ACTIVE_CODE, trigup, trigdown, coarse, load_en} registered once. All decisions use the registered copy, so there is one cycle of input latency.
- Step size inc = coarse ? COARSE_MULT : 1.
- States:
  - IDLE:
    - load_en has priority: pct <= min(load_pct, MAX_PCT); go to CONV. load_en works regardless of active.
    - else if active-match & up & !down: pct <= min(pct+inc, MAX_PCT); go to CONV.
    - else if active-match & down & !up: pct <= (pct>=inc) ? pct-inc : 0; go to CONV.
    - up & down together, or no active match: stay in IDLE, no change.
  - Saturated requests (up at MAX_PCT, down at 0) still pass through CONV and HOLD and pulse done.
  - Arithmetic uses PCT_W+1 bits internally; no wrap-around is permitted.
  - word_out <= pct*STEP, registered. It updates the cycle after pct updates; constant multiply is allowed.
  - CONV: double-dabble over PCT_W bits, two cycles per bit.
    - Add-3 cycle: every BCD digit >=5 gets +3.
    - Shift cycle: shift left 1; bit counter +1.
    - After PCT_W shifts: pct_bcd latched, done=1 for one cycle, go to HOLD.
    - Conversion latency: 2*PCT_W+1 cycles from CONV entry to done.
  - HOLD: counter increments until bit HOLDOFF_W-1 is set, then clears and returns to IDLE. All triggers and load_en are ignored, not queued.
- busy = (state != IDLE).
- Illegal state encodings return to IDLE.
- pct_bcd and word_out stay stable between updates.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CONV, HOLD)
  - ACTIVE_* menu codes (amp 4'h2, others)
  - function bcd_digits(n) for sizing
- One sub-module, bin2bcd_seq: parametrised sequential double-dabble.
  - Ports: start, bin, bcd, done.
  - Reused by the frequency and phase steppers.

Test Plan (default params, HOLDOFF_W=4 on bench):
- Reset with rst_n=0 mid-run → word_out=0, pct_bcd=12'h000, busy=0 asynchronously, before the next clk edge.
- active=2, trigup pulse from 0 → word_out=163, pct_bcd=12'h001, one done pulse; busy high through the 8-cycle holdoff.
- pct=95, coarse=1, trigup → pct clamps at 100, word_out=16300, pct_bcd=12'h100. Repeat trigup → values unchanged, done still pulses.
- pct=3, coarse=1, trigdown → pct=0, word_out=0, pct_bcd=12'h000. Then trigup and trigdown together → no state change, busy stays 0.
- load_en with load_pct=127 (active=0) → pct=100, pct_bcd=12'h100. trigup while busy → ignored, no extra done after holdoff.
- active=4'h3, trigup held → no change. Switch active to 2 while trigup is held → one step per holdoff period: 1, 2, 3… with correct BCD each time.
